// File: rtl/play_time_bcd_pkg.sv
// Shared definitions for the playback-time formatter: channel indices,
// scheduler state encoding, BCD digit limits and the output width helper.
package play_time_pkg;

    localparam logic [1:0] CH_ELAPSED = 2'd0;
    localparam logic [1:0] CH_TOTAL   = 2'd1;
    localparam logic [1:0] CH_REMAIN  = 2'd2;

    typedef enum logic [1:0] {
        ST_SCAN  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_STORE = 2'd3
    } state_t;

    localparam logic [3:0] SEC_ONES_MAX  = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX  = 4'd5;
    localparam logic [3:0] MIN_DIGIT_MAX = 4'd9;

    // Packed time width: minute digits plus two second digits.
    function automatic int unsigned time_w(input int unsigned min_digits);
        return 4 * min_digits + 8;
    endfunction

    // Round-robin channel successor.
    function automatic logic [1:0] next_ch(input logic [1:0] c);
        return (c == CH_REMAIN) ? CH_ELAPSED : c + 2'd1;
    endfunction

endpackage

// File: rtl/play_time_bcd_counter.sv
// Saturating BCD M..M:SS up-counter shared by all channels.
// Ports: clk, rst (sync, active-high), clr (zero value and sat),
//        inc (add one second), value (packed BCD), sat (increment hit max).
module bcd_time_counter
    import play_time_pkg::*;
#(
    parameter int unsigned  MIN_DIGITS = 2,
    localparam int unsigned TIME_W     = time_w(MIN_DIGITS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [TIME_W-1:0] value,
    output logic              sat
);

    localparam int unsigned NUM_DIGITS = MIN_DIGITS + 2;

    logic [TIME_W-1:0] value_next_c;
    logic              at_max_c;
    logic              carry_c;

    // Digit 0 is seconds ones, digit 1 seconds tens, the rest minutes.
    function automatic logic [3:0] digit_max(input int unsigned d);
        if (d == 0) return SEC_ONES_MAX;
        if (d == 1) return SEC_TENS_MAX;
        return MIN_DIGIT_MAX;
    endfunction

    // Ripple the +1 through the digit chain and detect 9..9:59.
    always_comb begin
        value_next_c = value;
        at_max_c     = 1'b1;
        carry_c      = 1'b1;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (value[4*d +: 4] != digit_max(d)) begin
                at_max_c = 1'b0;
            end
            if (carry_c) begin
                if (value[4*d +: 4] == digit_max(d)) begin
                    value_next_c[4*d +: 4] = 4'd0;
                end else begin
                    value_next_c[4*d +: 4] = value[4*d +: 4] + 4'd1;
                    carry_c                = 1'b0;
                end
            end
        end
    end

    // At the maximum the value holds and sat latches until the next clear.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
            sat   <= 1'b0;
        end else if (inc) begin
            if (at_max_c) begin
                sat <= 1'b1;
            end else begin
                value <= value_next_c;
            end
        end
    end

endmodule

// File: rtl/play_time_bcd.sv
// Playback-time formatter: converts elapsed, total and remaining seconds
// into packed BCD M..M:SS using one shared counter, one channel at a time.
// Ports: sys_clk, sys_rst (sync, active-high), ram_addr_out (elapsed source),
//        music_len (total source), remain_en (enable remaining channel),
//        time_elapsed/time_total/time_remain (BCD outputs),
//        time_upd (per-channel update pulse), time_ovf (per-channel
//        saturation), busy (conversion in progress).
module play_time_bcd
    import play_time_pkg::*;
#(
    parameter int unsigned  ADDR_W     = 12,
    parameter int unsigned  SHIFT      = 2,
    parameter int unsigned  MIN_DIGITS = 2,
    localparam int unsigned TIME_W     = time_w(MIN_DIGITS)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [ADDR_W-1:0] ram_addr_out,
    input  logic [ADDR_W-1:0] music_len,
    input  logic              remain_en,
    output logic [TIME_W-1:0] time_elapsed,
    output logic [TIME_W-1:0] time_total,
    output logic [TIME_W-1:0] time_remain,
    output logic [2:0]        time_upd,
    output logic [2:0]        time_ovf,
    output logic              busy
);

    localparam int unsigned CNT_W = ADDR_W - SHIFT;

    state_t            state, state_next;
    logic [1:0]        ch, ch_next;
    logic [CNT_W-1:0]  tgt_e_c, tgt_t_c, tgt_r_c, tgt_cur_c, last_cur_c;
    logic [CNT_W-1:0]  last_e, last_t, last_r;
    logic [CNT_W-1:0]  goal, idx;
    logic              remain_valid, remain_en_q;
    logic              stale_c;
    logic              cnt_clr_c, cnt_inc_c;
    logic [TIME_W-1:0] cnt_value;
    logic              cnt_sat;

    // Whole-second targets; remaining time clamps at zero past the end.
    assign tgt_e_c = CNT_W'(ram_addr_out >> SHIFT);
    assign tgt_t_c = CNT_W'(music_len >> SHIFT);
    assign tgt_r_c = (tgt_e_c > tgt_t_c) ? '0 : (tgt_t_c - tgt_e_c);

    // Select target and last-converted value of the current channel.
    always_comb begin
        tgt_cur_c  = tgt_e_c;
        last_cur_c = last_e;
        case (ch)
            CH_TOTAL: begin
                tgt_cur_c  = tgt_t_c;
                last_cur_c = last_t;
            end
            CH_REMAIN: begin
                tgt_cur_c  = tgt_r_c;
                last_cur_c = last_r;
            end
            default: ;
        endcase
    end

    // An invalidated remain slot reconverts even when R itself is unchanged.
    assign stale_c = (tgt_cur_c != last_cur_c) || ((ch == CH_REMAIN) && !remain_valid);

    // Scheduler next-state and counter controls.
    always_comb begin
        state_next = state;
        ch_next    = ch;
        cnt_clr_c  = 1'b0;
        cnt_inc_c  = 1'b0;
        case (state)
            ST_SCAN: begin
                if ((ch == CH_REMAIN) && !remain_en) begin
                    ch_next = CH_ELAPSED;
                end else if (stale_c) begin
                    state_next = ST_LOAD;
                end else begin
                    ch_next = next_ch(ch);
                end
            end
            ST_LOAD: begin
                cnt_clr_c  = 1'b1;
                state_next = (tgt_cur_c != '0) ? ST_COUNT : ST_STORE;
            end
            ST_COUNT: begin
                cnt_inc_c = 1'b1;
                if ((idx + CNT_W'(1)) == goal) begin
                    state_next = ST_STORE;
                end
            end
            ST_STORE: begin
                state_next = ST_SCAN;
                ch_next    = next_ch(ch);
            end
            default: state_next = ST_SCAN;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_SCAN;
        end else begin
            state <= state_next;
        end
    end

    // Channel pointer, snapshots and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ch           <= CH_ELAPSED;
            goal         <= '0;
            idx          <= '0;
            last_e       <= '0;
            last_t       <= '0;
            last_r       <= '0;
            remain_valid <= 1'b1;
            // A level held through reset is not treated as a rising edge.
            remain_en_q  <= remain_en;
            time_elapsed <= '0;
            time_total   <= '0;
            time_remain  <= '0;
            time_upd     <= '0;
            time_ovf     <= '0;
            busy         <= 1'b0;
        end else begin
            ch          <= ch_next;
            busy        <= (state_next != ST_SCAN);
            time_upd    <= '0;
            remain_en_q <= remain_en;
            if (remain_en && !remain_en_q) begin
                remain_valid <= 1'b0;
            end
            case (state)
                ST_LOAD: begin
                    goal <= tgt_cur_c;
                    idx  <= '0;
                    case (ch)
                        CH_ELAPSED: last_e <= tgt_cur_c;
                        CH_TOTAL:   last_t <= tgt_cur_c;
                        CH_REMAIN: begin
                            last_r       <= tgt_cur_c;
                            remain_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_COUNT: idx <= idx + CNT_W'(1);
                ST_STORE: begin
                    case (ch)
                        CH_ELAPSED: begin
                            time_elapsed <= cnt_value;
                            time_ovf[0]  <= cnt_sat;
                            time_upd     <= 3'b001;
                        end
                        CH_TOTAL: begin
                            time_total  <= cnt_value;
                            time_ovf[1] <= cnt_sat;
                            time_upd    <= 3'b010;
                        end
                        CH_REMAIN: begin
                            time_remain <= cnt_value;
                            time_ovf[2] <= cnt_sat;
                            time_upd    <= 3'b100;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    bcd_time_counter #(
        .MIN_DIGITS (MIN_DIGITS)
    ) u_counter (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .clr   (cnt_clr_c),
        .inc   (cnt_inc_c),
        .value (cnt_value),
        .sat   (cnt_sat)
    );

endmodule

// File: tb/tb_play_time_bcd.sv
// Bench for play_time_bcd: directed and random input steps checked against
// an arithmetic model of seconds, minutes and update scheduling.
module tb_play_time_bcd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sys_rst;
    logic [11:0] ram_addr, music_len;
    logic        remain_en;
    logic [15:0] time_elapsed, time_total, time_remain;
    logic [2:0]  time_upd, time_ovf;
    logic        busy;

    logic [11:0] ram1, len1;
    logic        ren1;
    logic [11:0] te1, tt1, tr1;
    logic [2:0]  upd1, ovf1;
    logic        busy1;

    play_time_bcd dut (
        .sys_clk      (clk),
        .sys_rst      (sys_rst),
        .ram_addr_out (ram_addr),
        .music_len    (music_len),
        .remain_en    (remain_en),
        .time_elapsed (time_elapsed),
        .time_total   (time_total),
        .time_remain  (time_remain),
        .time_upd     (time_upd),
        .time_ovf     (time_ovf),
        .busy         (busy)
    );

    play_time_bcd #(.ADDR_W(12), .SHIFT(0), .MIN_DIGITS(1)) dut1 (
        .sys_clk      (clk),
        .sys_rst      (sys_rst),
        .ram_addr_out (ram1),
        .music_len    (len1),
        .remain_en    (ren1),
        .time_elapsed (te1),
        .time_total   (tt1),
        .time_remain  (tr1),
        .time_upd     (upd1),
        .time_ovf     (ovf1),
        .busy         (busy1)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_last [3];
    bit          m_ren_prev;
    logic [31:0] m_rem_out;
    int          exp_cnt [3];
    int          obs_cnt [3];
    int          upd_seq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Seconds to packed BCD minutes:seconds, clamped at 9..9:59.
    function automatic logic [31:0] to_bcd(input int secs, input int md);
        int maxs, s, m, sec;
        logic [31:0] r;
        maxs = 60;
        for (int i = 0; i < md; i++) maxs = maxs * 10;
        maxs = maxs - 1;
        s   = (secs > maxs) ? maxs : secs;
        m   = s / 60;
        sec = s % 60;
        r   = 32'(sec % 10) | (32'(sec / 10) << 4);
        for (int i = 0; i < md; i++) begin
            r = r | (32'(m % 10) << (8 + 4 * i));
            m = m / 10;
        end
        return r;
    endfunction

    function automatic int remain_of(input int e, input int t);
        return (e > t) ? 0 : t - e;
    endfunction

    function automatic logic [31:0] exp_of(input int c);
        int e, t;
        e = int'(ram_addr) / 4;
        t = int'(music_len) / 4;
        if (c == 0) return to_bcd(e, 2);
        if (c == 1) return to_bcd(t, 2);
        return to_bcd(remain_of(e, t), 2);
    endfunction

    // Pulse monitor: one-hot, value matches the current inputs, logs order.
    always @(negedge clk) begin
        if (time_upd != 3'b000) begin
            check("upd_onehot", 32'($countones(time_upd)), 32'd1);
            if (time_upd[0]) begin
                obs_cnt[0]++; upd_seq.push_back(0);
                check("upd_val_elapsed", 32'(time_elapsed), exp_of(0));
            end
            if (time_upd[1]) begin
                obs_cnt[1]++; upd_seq.push_back(1);
                check("upd_val_total", 32'(time_total), exp_of(1));
            end
            if (time_upd[2]) begin
                obs_cnt[2]++; upd_seq.push_back(2);
                check("upd_val_remain", 32'(time_remain), exp_of(2));
            end
        end
    end

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_last[c]  = 0;
            obs_cnt[c] = 0;
            exp_cnt[c] = 0;
        end
        m_ren_prev = remain_en;
        m_rem_out  = 32'd0;
        upd_seq.delete();
    endtask

    // Apply new inputs and predict which channels must refresh.
    task automatic drive(input int ram, input int len, input bit ren);
        int e, t, r;
        e = ram / 4;
        t = len / 4;
        r = remain_of(e, t);
        exp_cnt[0] = (e != m_last[0]) ? 1 : 0;
        exp_cnt[1] = (t != m_last[1]) ? 1 : 0;
        m_last[0] = e;
        m_last[1] = t;
        if (ren) begin
            exp_cnt[2] = ((r != m_last[2]) || !m_ren_prev) ? 1 : 0;
            m_last[2]  = r;
            m_rem_out  = to_bcd(r, 2);
        end else begin
            exp_cnt[2] = 0;
        end
        m_ren_prev = ren;
        for (int c = 0; c < 3; c++) obs_cnt[c] = 0;
        upd_seq.delete();
        ram_addr  = 12'(ram);
        music_len = 12'(len);
        remain_en = ren;
    endtask

    task automatic wait_idle(input string tag);
        int quiet, cyc;
        quiet = 0;
        cyc   = 0;
        while (quiet < 8 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (busy || (time_upd != 3'b000)) quiet = 0;
            else quiet++;
        end
        check({tag, "_idle"}, 32'(quiet >= 8), 32'd1);
    endtask

    task automatic finish_step(input string tag);
        wait_idle(tag);
        for (int c = 0; c < 3; c++)
            check($sformatf("%s_cnt%0d", tag, c), 32'(obs_cnt[c]), 32'(exp_cnt[c]));
        check({tag, "_elapsed"}, 32'(time_elapsed), to_bcd(m_last[0], 2));
        check({tag, "_total"},   32'(time_total),   to_bcd(m_last[1], 2));
        check({tag, "_remain"},  32'(time_remain),  m_rem_out);
        check({tag, "_ovf"},     32'(time_ovf),     32'd0);
    endtask

    // Cycles from the LOAD cycle (busy first seen) to the update pulse.
    task automatic measure_lat(input bit which, output int lat);
        int w;
        w   = 0;
        lat = 0;
        while (((which ? busy1 : busy) == 1'b0) && w < 200) begin
            @(negedge clk);
            w++;
        end
        while (((which ? upd1 : time_upd) == 3'b000) && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        #1;
    endtask

    initial begin
        int lat, w;
        sys_rst   = 1'b1;
        ram_addr  = '0;
        music_len = '0;
        remain_en = 1'b0;
        ram1      = '0;
        len1      = '0;
        ren1      = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_elapsed", 32'(time_elapsed), 32'd0);
        check("rst_total",   32'(time_total),   32'd0);
        check("rst_remain",  32'(time_remain),  32'd0);
        check("rst_upd",     32'(time_upd),     32'd0);
        check("rst_ovf",     32'(time_ovf),     32'd0);
        check("rst_busy",    32'(busy),         32'd0);
        sys_rst = 1'b0;
        model_reset();

        // Zero inputs after reset must not start any conversion.
        repeat (20) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_pulses", 32'(obs_cnt[0] + obs_cnt[1] + obs_cnt[2]), 32'd0);

        // 240 address units = 60 s -> 01:00 after 62 cycles.
        drive(240, 0, 1'b0);
        measure_lat(1'b0, lat);
        check("lat_60s", 32'(lat), 32'd62);
        check("el_0100", 32'(time_elapsed), 32'h0100);
        check("upd_001", 32'(time_upd), 32'b001);
        check("total_still0", 32'(time_total), 32'd0);
        check("total_nopulse", 32'(obs_cnt[1]), 32'd0);

        // Pointer now sits on total, so total converts before remain.
        drive(240, 4095, 1'b1);
        finish_step("full");
        check("total_1703", 32'(time_total), 32'h1703);
        check("remain_1603", 32'(time_remain), 32'h1603);
        check("order_len", 32'(upd_seq.size()), 32'd2);
        if (upd_seq.size() == 2) begin
            check("order_first", 32'(upd_seq[0]), 32'd1);
            check("order_second", 32'(upd_seq[1]), 32'd2);
        end

        // Elapsed past the end: remaining clamps to zero.
        drive(400, 200, 1'b1);
        finish_step("clamp");
        check("remain_0000", 32'(time_remain), 32'h0000);
        check("el_0140", 32'(time_elapsed), 32'h0140);

        // Reset in the middle of a 60 s conversion.
        drive(240, 200, 1'b1);
        w = 0;
        while (!busy && w < 200) begin
            @(negedge clk);
            w++;
        end
        repeat (10) @(negedge clk);
        sys_rst = 1'b1;
        @(negedge clk);
        check("abort_elapsed", 32'(time_elapsed), 32'd0);
        check("abort_total",   32'(time_total),   32'd0);
        check("abort_remain",  32'(time_remain),  32'd0);
        check("abort_upd",     32'(time_upd),     32'd0);
        check("abort_busy",    32'(busy),         32'd0);
        check("abort_nopulse", 32'(obs_cnt[0]),   32'd0);
        @(negedge clk);
        sys_rst = 1'b0;
        model_reset();
        drive(240, 200, 1'b1);
        finish_step("reconv");
        check("reconv_0100", 32'(time_elapsed), 32'h0100);

        // Remain disabled: held while inputs move, then forced on re-enable.
        drive(100, 2000, 1'b0);
        finish_step("hold1");
        drive(240, 200, 1'b0);
        finish_step("hold2");
        drive(240, 200, 1'b1);
        finish_step("reenable");
        check("forced_remain", 32'(obs_cnt[2]), 32'd1);

        // Random steps.
        for (int i = 0; i < 10; i++) begin
            drive(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                  1'($urandom_range(0, 1)));
            finish_step($sformatf("rnd%0d", i));
        end

        // One minute digit, no scaling: 600 s saturates at 9:59.
        len1 = 12'd600;
        measure_lat(1'b1, lat);
        check("sat_lat", 32'(lat), 32'd602);
        check("sat_total", 32'(tt1), 32'h959);
        check("sat_model", 32'(tt1), to_bcd(600, 1));
        check("sat_upd", 32'(upd1), 32'b010);
        check("sat_ovf", 32'(ovf1), 32'b010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
